// File: rtl/ptab_ring.sv
// Prediction target address buffer: in-order ring of predicted branches, resolved out of order.
// Oldest mispredict squashes younger entries and raises a registered redirect; head retires in order.
module ptab_ring #(
    parameter int unsigned FETCH_W = 4,
    parameter int unsigned DEPTH   = 16,
    parameter int unsigned XLEN    = 32,
    parameter int unsigned NUM_BRU = 2,
    parameter int unsigned TAG_W   = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       pipe_flush,
    input  logic                       fetch_valid,
    input  logic [FETCH_W-1:0]         fetch_slot_valid,
    input  logic [FETCH_W-1:0]         fetch_slot_is_br,
    input  logic [FETCH_W-1:0]         fetch_slot_pred_taken,
    input  logic [FETCH_W*XLEN-1:0]    fetch_slot_pc,
    input  logic [FETCH_W*XLEN-1:0]    fetch_slot_pred_target,
    output logic                       fetch_ready,
    output logic [FETCH_W*TAG_W-1:0]   fetch_slot_tag,
    output logic [FETCH_W-1:0]         fetch_slot_tag_valid,
    input  logic [NUM_BRU-1:0]         bru_valid,
    input  logic [NUM_BRU*TAG_W-1:0]   bru_tag,
    input  logic [NUM_BRU-1:0]         bru_taken,
    input  logic [NUM_BRU*XLEN-1:0]    bru_target,
    output logic                       redirect_valid,
    output logic [XLEN-1:0]            redirect_pc,
    output logic [TAG_W-1:0]           redirect_tag,
    output logic                       upd_valid,
    output logic [XLEN-1:0]            upd_pc,
    output logic [XLEN-1:0]            upd_target,
    output logic                       upd_taken,
    output logic                       upd_misp
);

    localparam int unsigned PTR_W = TAG_W + 1;
    typedef logic [TAG_W-1:0] tag_t;
    typedef logic [PTR_W-1:0] ptr_t;

    ptr_t head_q, tail_q, tail_d, count, alloc_cnt;
    tag_t head_idx;

    logic [DEPTH-1:0] valid_q, valid_d, resolved_q, resolved_d;
    logic [DEPTH-1:0] misp_q, misp_d, pred_taken_q, pred_taken_d, act_taken_q, act_taken_d;
    logic [XLEN-1:0]  pc_q [DEPTH];
    logic [XLEN-1:0]  pc_d [DEPTH];
    logic [XLEN-1:0]  pred_target_q [DEPTH];
    logic [XLEN-1:0]  pred_target_d [DEPTH];
    logic [XLEN-1:0]  act_target_q [DEPTH];
    logic [XLEN-1:0]  act_target_d [DEPTH];

    logic             redirect_valid_q;
    logic [XLEN-1:0]  redirect_pc_q;
    tag_t             redirect_tag_q;

    logic [FETCH_W-1:0] eligible;
    tag_t               slot_tag [FETCH_W];
    logic               taken_seen;
    logic               alloc_en;

    tag_t               res_tag [NUM_BRU];
    tag_t               res_age [NUM_BRU];
    logic [XLEN-1:0]    res_target [NUM_BRU];
    logic [XLEN-1:0]    res_pc [NUM_BRU];
    logic [NUM_BRU-1:0] res_hit, res_misp, res_wr;

    logic               squash;
    tag_t               win_tag, win_age;
    logic [XLEN-1:0]    win_pc;
    logic               retire;

    assign head_idx    = head_q[TAG_W-1:0];
    assign count       = tail_q - head_q;
    assign fetch_ready = (count <= ptr_t'(DEPTH - FETCH_W));

    // Slots after the first predicted-taken branch are never fetched, so they get no entry.
    always_comb begin
        taken_seen     = 1'b0;
        alloc_cnt      = '0;
        eligible       = '0;
        fetch_slot_tag = '0;
        for (int i = 0; i < FETCH_W; i++) begin
            eligible[i] = fetch_slot_valid[i] & fetch_slot_is_br[i] & ~taken_seen;
            slot_tag[i] = tail_q[TAG_W-1:0] + alloc_cnt[TAG_W-1:0];
            fetch_slot_tag[i*TAG_W +: TAG_W] = slot_tag[i];
            alloc_cnt = alloc_cnt + ptr_t'(eligible[i]);
            if (eligible[i] & fetch_slot_pred_taken[i]) begin
                taken_seen = 1'b1;
            end
        end
    end

    assign fetch_slot_tag_valid = (fetch_valid & fetch_ready) ? eligible : '0;

    // Oldest mispredict wins; age is measured from the head so the wrap is transparent.
    always_comb begin
        squash  = 1'b0;
        win_tag = '0;
        win_age = '0;
        win_pc  = '0;
        for (int p = 0; p < NUM_BRU; p++) begin
            res_tag[p]    = bru_tag[p*TAG_W +: TAG_W];
            res_target[p] = bru_target[p*XLEN +: XLEN];
            res_age[p]    = res_tag[p] - head_idx;
            res_hit[p]    = bru_valid[p] & valid_q[res_tag[p]];
            res_misp[p]   = (pred_taken_q[res_tag[p]] != bru_taken[p]) |
                            (bru_taken[p] & (pred_target_q[res_tag[p]] != res_target[p]));
            res_pc[p]     = bru_taken[p] ? res_target[p] : pc_q[res_tag[p]] + XLEN'(4);
            if (res_hit[p] & res_misp[p] & (~squash | (res_age[p] < win_age))) begin
                squash  = 1'b1;
                win_tag = res_tag[p];
                win_age = res_age[p];
                win_pc  = res_pc[p];
            end
        end
        for (int p = 0; p < NUM_BRU; p++) begin
            res_wr[p] = res_hit[p] & ~pipe_flush & ~(squash & (res_age[p] > win_age));
        end
    end

    assign alloc_en = fetch_valid & fetch_ready & ~squash & ~pipe_flush;
    assign retire   = valid_q[head_idx] & resolved_q[head_idx];

    always_comb begin
        if (squash) begin
            tail_d = head_q + {1'b0, win_age} + ptr_t'(1);
        end else if (alloc_en) begin
            tail_d = tail_q + alloc_cnt;
        end else begin
            tail_d = tail_q;
        end
    end

    always_comb begin
        tag_t age;
        valid_d       = valid_q;
        resolved_d    = resolved_q;
        misp_d        = misp_q;
        pred_taken_d  = pred_taken_q;
        act_taken_d   = act_taken_q;
        pc_d          = pc_q;
        pred_target_d = pred_target_q;
        act_target_d  = act_target_q;
        age           = '0;
        if (pipe_flush) begin
            valid_d = '0;
        end else begin
            if (retire) begin
                valid_d[head_idx] = 1'b0;
            end
            for (int j = 0; j < DEPTH; j++) begin
                age = tag_t'(j) - head_idx;
                if (squash && (age > win_age)) begin
                    valid_d[j] = 1'b0;
                end
            end
            for (int p = 0; p < NUM_BRU; p++) begin
                if (res_wr[p]) begin
                    resolved_d[res_tag[p]]   = 1'b1;
                    misp_d[res_tag[p]]       = res_misp[p];
                    act_taken_d[res_tag[p]]  = bru_taken[p];
                    act_target_d[res_tag[p]] = res_target[p];
                end
            end
            if (alloc_en) begin
                for (int i = 0; i < FETCH_W; i++) begin
                    if (eligible[i]) begin
                        valid_d[slot_tag[i]]       = 1'b1;
                        resolved_d[slot_tag[i]]    = 1'b0;
                        misp_d[slot_tag[i]]        = 1'b0;
                        pred_taken_d[slot_tag[i]]  = fetch_slot_pred_taken[i];
                        pc_d[slot_tag[i]]          = fetch_slot_pc[i*XLEN +: XLEN];
                        pred_target_d[slot_tag[i]] = fetch_slot_pred_target[i*XLEN +: XLEN];
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q           <= '0;
            tail_q           <= '0;
            valid_q          <= '0;
            resolved_q       <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            redirect_tag_q   <= '0;
        end else if (pipe_flush) begin
            head_q           <= '0;
            tail_q           <= '0;
            valid_q          <= '0;
            resolved_q       <= resolved_d;
            redirect_valid_q <= 1'b0;
        end else begin
            head_q           <= head_q + ptr_t'(retire);
            tail_q           <= tail_d;
            valid_q          <= valid_d;
            resolved_q       <= resolved_d;
            redirect_valid_q <= squash;
            if (squash) begin
                redirect_pc_q  <= win_pc;
                redirect_tag_q <= win_tag;
            end
        end
    end

    // Payload is only ever read behind a valid bit, so it needs no reset.
    always_ff @(posedge clk) begin
        misp_q        <= misp_d;
        pred_taken_q  <= pred_taken_d;
        act_taken_q   <= act_taken_d;
        pc_q          <= pc_d;
        pred_target_q <= pred_target_d;
        act_target_q  <= act_target_d;
    end

    assign redirect_valid = redirect_valid_q;
    assign redirect_pc    = redirect_pc_q;
    assign redirect_tag   = redirect_tag_q;

    assign upd_valid  = retire & ~pipe_flush;
    assign upd_pc     = upd_valid ? pc_q[head_idx] : '0;
    assign upd_target = upd_valid ? act_target_q[head_idx] : '0;
    assign upd_taken  = upd_valid & act_taken_q[head_idx];
    assign upd_misp   = upd_valid & misp_q[head_idx];

endmodule

// File: tb/tb_ptab_ring.sv
// Directed bench for ptab_ring: allocation, out-of-order resolution, squash, wrap and flush.
module tb_ptab_ring;

    localparam int FETCH_W = 4;
    localparam int DEPTH   = 16;
    localparam int XLEN    = 32;
    localparam int NUM_BRU = 2;
    localparam int TAG_W   = 4;

    logic                     clk;
    logic                     rst_n;
    logic                     pipe_flush;
    logic                     fetch_valid;
    logic [FETCH_W-1:0]       fetch_slot_valid;
    logic [FETCH_W-1:0]       fetch_slot_is_br;
    logic [FETCH_W-1:0]       fetch_slot_pred_taken;
    logic [FETCH_W*XLEN-1:0]  fetch_slot_pc;
    logic [FETCH_W*XLEN-1:0]  fetch_slot_pred_target;
    logic                     fetch_ready;
    logic [FETCH_W*TAG_W-1:0] fetch_slot_tag;
    logic [FETCH_W-1:0]       fetch_slot_tag_valid;
    logic [NUM_BRU-1:0]       bru_valid;
    logic [NUM_BRU*TAG_W-1:0] bru_tag;
    logic [NUM_BRU-1:0]       bru_taken;
    logic [NUM_BRU*XLEN-1:0]  bru_target;
    logic                     redirect_valid;
    logic [XLEN-1:0]          redirect_pc;
    logic [TAG_W-1:0]         redirect_tag;
    logic                     upd_valid;
    logic [XLEN-1:0]          upd_pc;
    logic [XLEN-1:0]          upd_target;
    logic                     upd_taken;
    logic                     upd_misp;

    int n_tests = 0;
    int n_fail  = 0;

    ptab_ring #(
        .FETCH_W (FETCH_W),
        .DEPTH   (DEPTH),
        .XLEN    (XLEN),
        .NUM_BRU (NUM_BRU)
    ) dut (
        .clk                    (clk),
        .rst_n                  (rst_n),
        .pipe_flush             (pipe_flush),
        .fetch_valid            (fetch_valid),
        .fetch_slot_valid       (fetch_slot_valid),
        .fetch_slot_is_br       (fetch_slot_is_br),
        .fetch_slot_pred_taken  (fetch_slot_pred_taken),
        .fetch_slot_pc          (fetch_slot_pc),
        .fetch_slot_pred_target (fetch_slot_pred_target),
        .fetch_ready            (fetch_ready),
        .fetch_slot_tag         (fetch_slot_tag),
        .fetch_slot_tag_valid   (fetch_slot_tag_valid),
        .bru_valid              (bru_valid),
        .bru_tag                (bru_tag),
        .bru_taken              (bru_taken),
        .bru_target             (bru_target),
        .redirect_valid         (redirect_valid),
        .redirect_pc            (redirect_pc),
        .redirect_tag           (redirect_tag),
        .upd_valid              (upd_valid),
        .upd_pc                 (upd_pc),
        .upd_target             (upd_target),
        .upd_taken              (upd_taken),
        .upd_misp               (upd_misp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    // Idle keeps a lone branch in slot 0 with fetch_valid low, so slot 0's tag shows the tail.
    task automatic idle();
        pipe_flush             = 1'b0;
        fetch_valid            = 1'b0;
        fetch_slot_valid       = 4'b0001;
        fetch_slot_is_br       = 4'b0001;
        fetch_slot_pred_taken  = '0;
        fetch_slot_pc          = '0;
        fetch_slot_pred_target = '0;
        bru_valid              = '0;
        bru_tag                = '0;
        bru_taken              = '0;
        bru_target             = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        idle();
        #1;
    endtask

    task automatic slot(input int i, input logic br, input logic pt, input logic [31:0] pc,
                        input logic [31:0] tgt);
        fetch_slot_valid[i]                 = 1'b1;
        fetch_slot_is_br[i]                 = br;
        fetch_slot_pred_taken[i]            = pt;
        fetch_slot_pc[i*XLEN +: XLEN]          = pc;
        fetch_slot_pred_target[i*XLEN +: XLEN] = tgt;
    endtask

    task automatic resolve(input int p, input logic [3:0] tag, input logic tk,
                           input logic [31:0] tgt);
        bru_valid[p]                = 1'b1;
        bru_tag[p*TAG_W +: TAG_W]   = tag;
        bru_taken[p]                = tk;
        bru_target[p*XLEN +: XLEN]  = tgt;
    endtask

    task automatic check_upd(input string name, input logic [31:0] pc, input logic tk,
                             input logic mp);
        check({name, "_valid"}, upd_valid, 1);
        check({name, "_pc"}, upd_pc, pc);
        check({name, "_taken"}, upd_taken, tk);
        check({name, "_misp"}, upd_misp, mp);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_redir_valid", redirect_valid, 0);
        check("rst_in_upd_valid", upd_valid, 0);
        rst_n = 1'b1;
        #2;
        check("rst_fetch_ready", fetch_ready, 1);
        check("rst_redir_pc", redirect_pc, 0);
        check("rst_redir_tag", redirect_tag, 0);
        check("rst_upd_pc", upd_pc, 0);
        check("rst_upd_target", upd_target, 0);
        check("rst_upd_taken", upd_taken, 0);
        check("rst_upd_misp", upd_misp, 0);
        check("rst_tail", fetch_slot_tag[3:0], 0);
        check("rst_idle_tag_valid", fetch_slot_tag_valid, 0);

        // Bundle: nt @100, t @104->200, br @108 cut off by the taken branch.
        fetch_valid = 1'b1;
        slot(0, 1, 0, 32'h100, 32'h180);
        slot(1, 1, 1, 32'h104, 32'h200);
        slot(2, 1, 0, 32'h108, 32'h0);
        #1;
        check("b1_tag_valid", fetch_slot_tag_valid, 4'b0011);
        check("b1_tag0", fetch_slot_tag[3:0], 0);
        check("b1_tag1", fetch_slot_tag[7:4], 1);
        tick();
        check("b1_tail", fetch_slot_tag[3:0], 2);
        check("b1_no_upd", upd_valid, 0);

        resolve(0, 1, 1, 32'h200);
        tick();
        check("t1_ok_no_redir", redirect_valid, 0);
        check("t1_head_blocks", upd_valid, 0);

        resolve(0, 0, 1, 32'h300);
        tick();
        check("t0_redir_valid", redirect_valid, 1);
        check("t0_redir_pc", redirect_pc, 32'h300);
        check("t0_redir_tag", redirect_tag, 0);
        check("t0_tail", fetch_slot_tag[3:0], 1);
        check_upd("t0_upd", 32'h100, 1, 1);
        check("t0_upd_target", upd_target, 32'h300);
        tick();
        check("t0_redir_pulse", redirect_valid, 0);
        check("t1_squashed", upd_valid, 0);
        check("t0_tail_hold", fetch_slot_tag[3:0], 1);

        // Bundle: nt @300, nt @304, non-branch, taken @30c->400.
        fetch_valid = 1'b1;
        slot(0, 1, 0, 32'h300, 32'h0);
        slot(1, 1, 0, 32'h304, 32'h0);
        slot(2, 0, 0, 32'h308, 32'h0);
        slot(3, 1, 1, 32'h30c, 32'h400);
        #1;
        check("b2_tag_valid", fetch_slot_tag_valid, 4'b1011);
        check("b2_tags", {fetch_slot_tag[15:12], fetch_slot_tag[7:0]}, 12'h321);
        tick();

        resolve(0, 2, 0, 32'h0);
        resolve(1, 1, 0, 32'h0);
        tick();
        check("b2_no_redir", redirect_valid, 0);
        check_upd("b2_upd1", 32'h300, 0, 0);
        tick();
        check_upd("b2_upd2", 32'h304, 0, 0);
        tick();
        check("b2_t3_pending", upd_valid, 0);

        // Four not-taken branches, tags 4..7; head is 3.
        fetch_valid = 1'b1;
        for (int k = 0; k < 4; k++) slot(k, 1, 0, 32'h500 + 32'(4 * k), 32'h0);
        #1;
        check("b3_tag_valid", fetch_slot_tag_valid, 4'b1111);
        tick();
        check("b3_tail", fetch_slot_tag[3:0], 8);

        resolve(0, 6, 1, 32'h600);
        resolve(1, 4, 1, 32'h700);
        tick();
        check("dual_redir_valid", redirect_valid, 1);
        check("dual_redir_tag", redirect_tag, 4);
        check("dual_redir_pc", redirect_pc, 32'h700);
        check("dual_tail", fetch_slot_tag[3:0], 5);

        resolve(0, 3, 1, 32'h400);
        tick();
        check("t3_no_redir", redirect_valid, 0);
        check_upd("t3_upd", 32'h30c, 1, 0);
        check("t3_upd_target", upd_target, 32'h400);
        tick();
        check_upd("t4_upd", 32'h500, 1, 1);
        check("t4_upd_target", upd_target, 32'h700);
        tick();
        check("t5_squashed", upd_valid, 0);

        // Fill from head=tail=5 with wrap: tags 5..15, 0, then 1 makes count 13.
        fetch_valid = 1'b1;
        for (int k = 0; k < 4; k++) slot(k, 1, 0, 32'h800 + 32'(4 * k), 32'h0);
        tick();
        check("f1_tail", fetch_slot_tag[3:0], 9);
        fetch_valid = 1'b1;
        for (int k = 0; k < 4; k++) slot(k, 1, 0, 32'h880 + 32'(4 * k), 32'h0);
        tick();
        check("f2_tail", fetch_slot_tag[3:0], 13);
        fetch_valid = 1'b1;
        for (int k = 0; k < 3; k++) slot(k, 1, 0, 32'hA00 + 32'(4 * k), 32'h0);
        slot(3, 1, 1, 32'hA0C, 32'hA00);
        #1;
        check("f3_tag_wrap15", fetch_slot_tag[11:8], 15);
        check("f3_tag_wrap0", fetch_slot_tag[15:12], 0);
        tick();
        check("f3_ready_at_12", fetch_ready, 1);
        check("f3_tail", fetch_slot_tag[3:0], 1);
        fetch_valid = 1'b1;
        slot(0, 1, 1, 32'h900, 32'h940);
        tick();
        check("f4_full", fetch_ready, 0);
        check("f4_tail", fetch_slot_tag[3:0], 2);
        fetch_valid = 1'b1;
        for (int k = 0; k < 4; k++) slot(k, 1, 0, 32'hD00 + 32'(4 * k), 32'h0);
        #1;
        check("full_tag_valid", fetch_slot_tag_valid, 0);
        tick();
        check("full_tail_hold", fetch_slot_tag[3:0], 2);

        resolve(0, 5, 0, 32'h0);
        tick();
        check_upd("f_retire", 32'h800, 0, 0);
        check("f_retire_still_full", fetch_ready, 0);
        tick();
        check("f_ready_again", fetch_ready, 1);
        check("f_t6_pending", upd_valid, 0);

        resolve(1, 1, 0, 32'h0);
        tick();
        check("nt_redir_valid", redirect_valid, 1);
        check("nt_redir_pc", redirect_pc, 32'h904);
        check("nt_redir_tag", redirect_tag, 1);
        check("nt_tail", fetch_slot_tag[3:0], 2);

        resolve(0, 0, 1, 32'hA40);
        tick();
        check("tgt_redir_pc", redirect_pc, 32'hA40);
        check("tgt_redir_tag", redirect_tag, 0);
        check("tgt_tail", fetch_slot_tag[3:0], 1);

        // Flush together with a mispredict and an allocation.
        pipe_flush  = 1'b1;
        resolve(0, 6, 1, 32'hB00);
        fetch_valid = 1'b1;
        for (int k = 0; k < 4; k++) slot(k, 1, 0, 32'hE00 + 32'(4 * k), 32'h0);
        #1;
        check("fl_ready_before", fetch_ready, 1);
        tick();
        check("fl_no_redir", redirect_valid, 0);
        check("fl_no_upd", upd_valid, 0);
        check("fl_ready", fetch_ready, 1);
        check("fl_tail", fetch_slot_tag[3:0], 0);
        resolve(0, 6, 1, 32'hB00);
        tick();
        check("fl_stale_ignored", redirect_valid, 0);
        fetch_valid = 1'b1;
        slot(0, 1, 0, 32'hC00, 32'h0);
        #1;
        check("fl_alloc_tag_valid", fetch_slot_tag_valid, 4'b0001);
        tick();
        check("fl_alloc_tail", fetch_slot_tag[3:0], 1);
        resolve(0, 0, 0, 32'h0);
        tick();
        check_upd("fl_upd", 32'hC00, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ptab_ring.md
# ptab_ring

Parametrised prediction target address buffer: a circular, in-order queue holding one entry per predicted branch in each fetch bundle. It sits between fetch/BTB and the branch units. Branches resolve out of order on multiple ports and are checked against their stored prediction. A mispredict squashes all younger entries and issues a registered redirect, and resolved entries retire in order to emit predictor update records.

## Interface
- FETCH_W, 4: slots per fetch bundle.
- DEPTH, 16: entries; power of two, ≥ 2*FETCH_W.
- XLEN, 32: address width.
- NUM_BRU, 2: branch resolution ports.
- TAG_W, $clog2(DEPTH): derived; not overridden.

Ports (all vectors packed, slot/port i at bits [i*W +: W]):
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- pipe_flush  in  1  full flush, synchronous.
- fetch_valid  in  1  bundle present.
- fetch_slot_valid  in  FETCH_W  slot holds an instruction.
- fetch_slot_is_br  in  FETCH_W  slot is a conditional branch/jump.
- fetch_slot_pred_taken  in  FETCH_W  predicted direction.
- fetch_slot_pc  in  FETCH_W*XLEN  slot PC.
- fetch_slot_pred_target  in  FETCH_W*XLEN  predicted target.
- fetch_ready  out  1  free entries ≥ FETCH_W.
- fetch_slot_tag  out  FETCH_W*TAG_W  tag assigned to each branch slot.
- fetch_slot_tag_valid  out  FETCH_W  slot received an entry.
- bru_valid  in  NUM_BRU  resolution present.
- bru_tag  in  NUM_BRU*TAG_W  entry being resolved.
- bru_taken  in  NUM_BRU  actual direction.
- bru_target  in  NUM_BRU*XLEN  actual taken target.
- redirect_valid  out  1  one-cycle pulse on mispredict.
- redirect_pc  out  XLEN  correct next fetch PC.
- redirect_tag  out  TAG_W  mispredicted entry.
- upd_valid  out  1  head retired this cycle.
- upd_pc, upd_target  out  XLEN each  retired branch PC / actual target.
- upd_taken, upd_misp  out  1 each  actual direction / was mispredicted.

## Operation
- Pointers head/tail are TAG_W+1 bits (wrap bit); empty: head==tail; count = tail-head; free = DEPTH-count.
- Allocation: slot i is eligible if valid & is_br and no lower slot is valid & is_br & pred_taken; slots after the first predicted-taken branch are ignored. Eligible slots get consecutive tags tail+prefix_count(eligible below i), mod DEPTH. Written only when fetch_valid & fetch_ready; tail advances by eligible count (0..FETCH_W).
- Entry fields: valid, resolved, misp, pc, pred_taken, pred_target, act_taken, act_target.
- Resolution port p: ignored if entry invalid or squashed this cycle. Mispredict = pred_taken≠taken, or taken & pred_target≠target. Sets resolved, misp, act fields.
- Correct PC: taken ? bru_target : pc+4.
- Multiple mispredicts same cycle: oldest wins, age = (tag-head) mod DEPTH, lower port on tie impossible (tags distinct). Winner: tail ← winner+1 (same wrap epoch as winner), entries younger invalidated, redirect registered.
- Mispredict beats allocation in the same cycle: bundle discarded, tail from squash only.
- Retire: if head entry valid & resolved (flop state at cycle start), emit upd_* and advance head by 1. Max one per cycle.
- pipe_flush: all valid cleared, head←tail←0, no redirect, pending redirect cancelled; overrides everything.

## Timing
- Reset: head=tail=0, all entries invalid, redirect_valid=0, upd_valid=0, redirect_pc/tag=0, upd_* = 0, fetch_ready=1.
- fetch_ready and fetch_slot_tag* combinational from flopped pointers and inputs; no input→fetch_ready path.
- Resolve in cycle T → redirect_valid/pc/tag at T+1 for exactly 1 cycle; younger entries invalid from T+1.
- Resolve in T → earliest retirement (upd_valid) in T+1.
- Entry allocated in T is resolvable from T+1.
- Full: count>DEPTH-FETCH_W ⇒ fetch_ready=0; wrap handled by pointer wrap bit.

## Test plan
- Reset, bundle {br nt @0x100, br t @0x104→0x200, br @0x108} -> tags 0,1 valid, slot2 tag_valid=0, tail=2.
- Resolve tag1 taken target 0x200 -> no redirect, head retires 0 only after tag0 resolves; upd_misp=0.
- Resolve tag0 taken 0x300 (predicted nt) -> T+1 redirect_pc=0x300, redirect_tag=0, tag1 invalidated, tail=1.
- Ports 0/1 mispredict tags 5 and 3 same cycle (head=2) -> redirect_tag=3, tail=4, tag5 result ignored.
- Fill to DEPTH-FETCH_W+1 with pointer wrap -> fetch_ready=0; retire one -> tags wrap 15→0 correctly.
- pipe_flush concurrent with mispredict and allocation -> no redirect, empty, fetch_ready=1 next cycle.
